// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the default bus widths, the transfer FSM state encoding and the
// requester identifiers used by mem_arbiter and mem_arbiter_pick.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 20;
  localparam int DATA_W_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_DMA = 1'b1
  } port_t;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Winner selection between the CPU and DMA requesters.
// Latency: combinational winner; the last-grant pointer updates on the grant edge.
// Backpressure: a port is ineligible while its own ack is high, so a held req is
//   only taken again one cycle after its ack.
//
// Ports:
//   clock, reset        system clock, synchronous active-high reset
//   cpu_req, dma_req    raw requests
//   cpu_ack, dma_ack    registered acks from the top (mask the just-served port)
//   grant               top accepts the winner at this edge (FSM in IDLE)
//   win_vld             at least one eligible requester
//   winner              selected port
//
// MEM_ARBITER_RR_EN selects round-robin (pointer present); otherwise DMA has
// fixed priority and no pointer exists.
module mem_arbiter_pick
  import mem_arbiter_pkg::*;
(
  input  logic  clock,
  input  logic  reset,
  input  logic  cpu_req,
  input  logic  dma_req,
  input  logic  cpu_ack,
  input  logic  dma_ack,
  input  logic  grant,
  output logic  win_vld,
  output port_t winner
);

  logic cpu_elig;
  logic dma_elig;

  // The ack is high in the cycle right after XFER; a requester has not yet
  // had a chance to drop req, so its req still reflects the served access.
  assign cpu_elig = cpu_req & ~cpu_ack;
  assign dma_elig = dma_req & ~dma_ack;
  assign win_vld  = cpu_elig | dma_elig;

`ifdef MEM_ARBITER_RR_EN

  port_t last_grant;

  // Reset to DMA so the first contested grant after reset goes to the CPU.
  always_ff @(posedge clock) begin
    if (reset) begin
      last_grant <= PORT_DMA;
    end else if (grant && win_vld) begin
      last_grant <= winner;
    end
  end

  always_comb begin
    winner = PORT_DMA;
    if (cpu_elig && dma_elig) begin
      winner = (last_grant == PORT_DMA) ? PORT_CPU : PORT_DMA;
    end else if (cpu_elig) begin
      winner = PORT_CPU;
    end
  end

`else

  // Fixed priority needs no state; these inputs only matter for round-robin.
  logic unused_rr;
  assign unused_rr = ^{clock, reset, grant};

  always_comb begin
    winner = PORT_DMA;
    if (!dma_elig && cpu_elig) begin
      winner = PORT_CPU;
    end
  end

`endif

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (CPU, DMA) arbiter onto a single shared memory bus.
// Latency: req sampled at edge N, bus active in cycle N+1, ack pulse in cycle N+2.
// Backpressure: requesters hold req until their one-cycle ack; at most one
//   transfer per two cycles, the served port sits out its ack cycle.
//
// Ports:
//   clock, reset                       system clock, synchronous active-high reset
//   cpu_req/address/we/out             CPU request, address, write strobe, write data
//   cpu_ack, cpu_in                    CPU completion pulse and captured read data
//   dma_req/address/we/out             DMA request (same semantics as CPU)
//   dma_ack, dma_in                    DMA completion pulse and captured read data
//   address, out, we                   registered shared memory bus
//   in                                 memory read data for the current address
//
// Build option: define MEM_ARBITER_RR_EN for round-robin arbitration; default is
// fixed DMA priority.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,

  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_address,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_out,
  output logic              cpu_ack,
  output logic [DATA_W-1:0] cpu_in,

  input  logic              dma_req,
  input  logic [ADDR_W-1:0] dma_address,
  input  logic              dma_we,
  input  logic [DATA_W-1:0] dma_out,
  output logic              dma_ack,
  output logic [DATA_W-1:0] dma_in,

  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] out,
  output logic              we,
  input  logic [DATA_W-1:0] in
);

  state_t state;
  port_t  owner;     // port whose access is on the bus during XFER
  logic   win_vld;
  port_t  winner;
  logic   grant;

  assign grant = (state == IDLE);

  mem_arbiter_pick u_pick (
    .clock   (clock),
    .reset   (reset),
    .cpu_req (cpu_req),
    .dma_req (dma_req),
    .cpu_ack (cpu_ack),
    .dma_ack (dma_ack),
    .grant   (grant),
    .win_vld (win_vld),
    .winner  (winner)
  );

  // Address, data and strobe are copied at the grant edge, so a requester
  // changing its fields afterwards cannot disturb the access in flight.
  // A reset landing on the XFER closing edge simply drops the access: no ack.
  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= IDLE;
      owner   <= PORT_CPU;
      we      <= 1'b0;
      address <= '0;
      out     <= '0;
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      cpu_in  <= '0;
      dma_in  <= '0;
    end else begin
      cpu_ack <= 1'b0;
      dma_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (win_vld) begin
            owner <= winner;
            state <= XFER;
            if (winner == PORT_DMA) begin
              address <= dma_address;
              out     <= dma_out;
              we      <= dma_we;
            end else begin
              address <= cpu_address;
              out     <= cpu_out;
              we      <= cpu_we;
            end
          end else begin
            we <= 1'b0;
          end
        end
        XFER: begin
          // Read data is captured on writes too; requesters ignore it then.
          we    <= 1'b0;
          state <= IDLE;
          if (owner == PORT_DMA) begin
            dma_in  <= in;
            dma_ack <= 1'b1;
          end else begin
            cpu_in  <= in;
            cpu_ack <= 1'b1;
          end
        end
        default: begin
          we    <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
